// File: rtl/seven_seg_capture.sv
// seven_seg_capture: recovers the hex digits shown on a multiplexed, active-low
// four-digit seven-segment display by sampling its anode and segment lines.
//
// Parameters
//   SETTLE_CYCLES : consecutive identical synchronized samples needed before a
//                   digit is captured (2..255)
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous active-low reset
//   an[3:0]     : anode enables, active-low, an[i] selects digit i
//   seg[6:0]    : segment lines, active-low, {g,f,e,d,c,b,a}
//   digits      : captured hex values, digit i at digits[4i+3:4i]
//   digit_valid : sticky, digit i captured with a legal glyph or blank
//   digit_err   : latest capture of digit i was an illegal pattern
//   blank       : latest capture of digit i had all segments off
//   frame_done  : one-cycle pulse once all four digits were captured
`timescale 1ns/1ps
module seven_seg_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  digit_err,
  output logic [3:0]  blank,
  output logic        frame_done
);

  // Capture fires on the matching sample that would bring the counter to
  // SETTLE_CYCLES-1, i.e. the SETTLE_CYCLES-th identical sample in a row.
  localparam logic [7:0] CntLast = 8'(SETTLE_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  an_meta_q, an_sync_q;
  logic [6:0]  seg_meta_q, seg_sync_q;
  logic [10:0] prev_q;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  valid_q, valid_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  blank_q, blank_d;
  logic [3:0]  seen_q, seen_d;
  logic        frame_q, frame_d;

  logic        active;
  logic [1:0]  idx;
  logic        same;
  logic        capture;
  logic        legal;
  logic [3:0]  value;

  // Synchronizers reset to the inactive level so reset release looks idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an_meta_q  <= 4'hF;
      an_sync_q  <= 4'hF;
      seg_meta_q <= 7'h7F;
      seg_sync_q <= 7'h7F;
      prev_q     <= 11'h7FF;
    end else begin
      an_meta_q  <= an;
      an_sync_q  <= an_meta_q;
      seg_meta_q <= seg;
      seg_sync_q <= seg_meta_q;
      prev_q     <= {an_sync_q, seg_sync_q};
    end
  end

  // Exactly one low anode bit means a digit is being driven.
  always_comb begin
    active = 1'b1;
    idx    = 2'd0;
    unique case (an_sync_q)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: active = 1'b0;
    endcase
  end

  assign same = ({an_sync_q, seg_sync_q} == prev_q);

  // Inverse of the hex glyph table (active-low, {g,f,e,d,c,b,a}).
  always_comb begin
    legal = 1'b1;
    value = 4'h0;
    case (seg_sync_q)
      7'h40: value = 4'h0;
      7'h79: value = 4'h1;
      7'h24: value = 4'h2;
      7'h30: value = 4'h3;
      7'h19: value = 4'h4;
      7'h12: value = 4'h5;
      7'h02: value = 4'h6;
      7'h78: value = 4'h7;
      7'h00: value = 4'h8;
      7'h10: value = 4'h9;
      7'h08: value = 4'hA;
      7'h03: value = 4'hB;
      7'h46: value = 4'hC;
      7'h21: value = 4'hD;
      7'h06: value = 4'hE;
      7'h0E: value = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (active) begin
          state_d = StSettle;
          cnt_d   = 8'd0;
        end
      end
      StSettle: begin
        if (same && active) begin
          if (cnt_q == CntLast) begin
            capture = 1'b1;
            state_d = StHeld;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          cnt_d   = 8'd0;
          state_d = active ? StSettle : StIdle;
        end
      end
      StHeld: begin
        // One capture per dwell: wait for the pattern to change.
        if (!same) begin
          cnt_d   = 8'd0;
          state_d = active ? StSettle : StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    blank_d  = blank_q;
    // A capture landing on the clearing cycle survives into the new mask.
    seen_d   = (seen_q == 4'hF) ? 4'h0 : seen_q;
    frame_d  = (seen_q == 4'hF);
    if (capture) begin
      seen_d[idx] = 1'b1;
      if (seg_sync_q == 7'h7F) begin
        blank_d[idx] = 1'b1;
        valid_d[idx] = 1'b1;
        err_d[idx]   = 1'b0;
      end else if (legal) begin
        digits_d[{idx, 2'b00} +: 4] = value;
        valid_d[idx] = 1'b1;
        err_d[idx]   = 1'b0;
        blank_d[idx] = 1'b0;
      end else begin
        err_d[idx]   = 1'b1;
        blank_d[idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      digits_q <= 16'h0;
      valid_q  <= 4'h0;
      err_q    <= 4'h0;
      blank_q  <= 4'h0;
      seen_q   <= 4'h0;
      frame_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      digits_q <= digits_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      blank_q  <= blank_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign digit_err   = err_q;
  assign blank       = blank_q;
  assign frame_done  = frame_q;

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, the number of consecutive identical synchronized samples (range 2..255) required before a digit is captured.
REQ-002 SHALL have port clk  input  1  system clock; all flops rising-edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port an  input  4  multiplexed anode enables, active-low, an[i] selects digit i.
REQ-005 SHALL have port seg  input  7  segment lines, active-low, seg[6:0] = g,f,e,d,c,b,a.
REQ-006 SHALL have port digits  output  16  captured hex values, digit i at digits[4i+3:4i].
REQ-007 SHALL have port digit_valid  output  4  sticky; bit i set once digit i has been captured with a legal glyph or blank.
REQ-008 SHALL have port digit_err  output  4  bit i set when the latest capture of digit i was not a legal glyph.
REQ-009 SHALL have port blank  output  4  bit i set when the latest capture of digit i was all segments off (seg = 7'h7F).
REQ-010 SHALL have port frame_done  output  1  one-cycle pulse when all four digits have been captured since the previous pulse.

Function
REQ-011 SHALL pass an and seg through a 2-flop synchronizer, resetting to all-ones (inactive) so reset release never produces a capture.
REQ-012 SHALL treat a sample as an active digit only when exactly one bit of the synchronized an is 0; an = 4'hF or two or more low bits means no active digit.
REQ-013 SHALL implement states IDLE, SETTLE, HELD.
REQ-014 SHALL in IDLE: go to SETTLE and clear the stability counter when an active digit is sampled; otherwise stay.
REQ-015 SHALL in SETTLE: increment the counter while {an,seg} equals the previous sample; on any mismatch, clear the counter (stay in SETTLE if still an active digit, else go to IDLE).
REQ-016 SHALL in SETTLE: when the counter reaches SETTLE_CYCLES-1 with a matching sample, capture that digit and go to HELD.
REQ-017 SHALL in HELD: perform no further capture; on any change of {an,seg}, go to SETTLE (active digit) or IDLE (no active digit). This limits capture to exactly one per dwell.
REQ-018 SHALL decode the captured pattern as the inverse of the team's hex glyph table. Examples: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, A = 7'h08, F = 7'h0E.
REQ-019 SHALL, on a legal glyph capture: update digits field i, set digit_valid[i], and clear digit_err[i] and blank[i].
REQ-020 SHALL, on a blank capture: leave digits field i unchanged, set blank[i] and digit_valid[i], and clear digit_err[i].
REQ-021 SHALL, on an illegal pattern capture: leave digits field i and digit_valid[i] unchanged, set digit_err[i], and clear blank[i].
REQ-022 SHALL register all outputs so they update on the edge that performs the capture; latency from a stable pattern at the pins to the output update is SETTLE_CYCLES+2 clk cycles.
REQ-023 SHALL keep a 4-bit seen mask, setting bit i on every capture of digit i, whatever its legality.
REQ-024 SHALL, on the cycle after the mask becomes 4'hF, assert frame_done for one cycle and clear the mask.
REQ-025 SHALL, when a capture coincides with that clear, leave the captured digit's bit set in the new mask.
REQ-026 SHALL count repeat captures of the same digit within a frame only once toward frame_done.

Reset
REQ-027 SHALL, while reset = 0 (asynchronously), force digits = 16'h0, digit_valid = 0, digit_err = 0, blank = 0, frame_done = 0, state = IDLE, counter = 0, and mask = 0.
REQ-028 SHALL, if reset asserts mid-SETTLE or mid-frame, discard all partial progress; after release, the first capture occurs no earlier than SETTLE_CYCLES+2 cycles.

Verification
REQ-029 SHALL pass: reset, then an = 4'b1110, seg = 7'h79 held 10 cycles, SETTLE_CYCLES = 4 -> digits[3:0] = 1 and digit_valid = 4'b0001 exactly 6 cycles after apply; no second capture.
REQ-030 SHALL pass: scan digits 0..3 with glyphs 0, 8, A, F, dwell 8 cycles each -> digits = 16'hFA80, frame_done pulses once for one cycle after the digit-3 capture.
REQ-031 SHALL pass: seg toggling 7'h40/7'h79 every 2 cycles on an = 4'b1101 -> no capture, outputs unchanged.
REQ-032 SHALL pass: an = 4'b1100 (two low) held 10 cycles -> no capture; digit 1 with seg = 7'h7F -> blank[1] = 1 and digits field unchanged.
REQ-033 SHALL pass: digit 2 with seg = 7'h55 (illegal) -> digit_err[2] = 1 and digit_valid[2] unchanged; a later legal glyph clears digit_err[2].
REQ-034 SHALL pass: reset pulsed low for 1 cycle 2 cycles before a capture -> all outputs 0 immediately, capture deferred by a full SETTLE_CYCLES+2.
